// File: rtl/lab4_btn_ctrl_if.sv
// Board-side signal bundle for the lab-4 button controller.
// Groups the raw buttons and the user-visible outputs.
//   usr_btn    : raw buttons [0] DEC_COUNTER, [1] INC_COUNTER, [2] DEC_PWM, [3] INC_PWM
//   usr_led    : signed two's-complement counter value, -8..7
//   pwm_signal : PWM output
//   duty_idx   : duty index 0..4 (5%, 25%, 50%, 75%, 100%)
//   busy       : a command was accepted and the buttons are not yet released
// Modports: master drives the buttons (board/bench), slave is the controller.
interface lab4_btn_ctrl_if;
  logic [3:0] usr_btn;
  logic [3:0] usr_led;
  logic       pwm_signal;
  logic [3:0] duty_idx;
  logic       busy;

  modport master (
    output usr_btn,
    input  usr_led,
    input  pwm_signal,
    input  duty_idx,
    input  busy
  );

  modport slave (
    input  usr_btn,
    output usr_led,
    output pwm_signal,
    output duty_idx,
    output busy
  );
endinterface

// File: rtl/lab4_btn_ctrl.sv
// Button-command controller for the lab-4 counter/PWM datapath.
// Synchronizes and debounces four buttons, turns each accepted press into
// exactly one command (fixed priority bit3 > bit2 > bit1 > bit0), drives a
// signed saturating LED counter and a 5-level PWM duty index, and generates
// the PWM output with duty changes taking effect only at period boundaries.
// Ports:
//   clk     : system clock, rising edge
//   reset_n : synchronous reset, active HIGH despite the name
//   bus     : lab4_btn_ctrl_if.slave (usr_btn in; usr_led, pwm_signal,
//             duty_idx, busy out)
module lab4_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int PWM_PERIOD      = 100
) (
  input  logic            clk,
  input  logic            reset_n,
  lab4_btn_ctrl_if.slave  bus
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int CNT_W = $clog2(PWM_PERIOD + 1);

  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_TAKE  = DB_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] PWM_LAST = CNT_W'(PWM_PERIOD - 1);

  localparam logic signed [3:0] LED_MAX = 4'sb0111;
  localparam logic signed [3:0] LED_MIN = 4'sb1000;
  localparam logic [3:0]        DUTY_MAX = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_FIRE, S_HOLD} state_t;

  // Saturating arithmetic helpers
  function automatic logic signed [3:0] sat_inc_led(input logic signed [3:0] v);
    return (v == LED_MAX) ? v : v + 4'sd1;
  endfunction

  function automatic logic signed [3:0] sat_dec_led(input logic signed [3:0] v);
    return (v == LED_MIN) ? v : v - 4'sd1;
  endfunction

  function automatic logic [3:0] sat_inc_duty(input logic [3:0] v);
    return (v >= DUTY_MAX) ? DUTY_MAX : v + 4'd1;
  endfunction

  function automatic logic [3:0] sat_dec_duty(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // High-time in clk cycles for each duty index, fixed at elaboration.
  function automatic logic [CNT_W-1:0] thr_of(input logic [3:0] idx);
    case (idx)
      4'd0:    return CNT_W'(PWM_PERIOD * 5 / 100);
      4'd1:    return CNT_W'(PWM_PERIOD * 25 / 100);
      4'd2:    return CNT_W'(PWM_PERIOD * 50 / 100);
      4'd3:    return CNT_W'(PWM_PERIOD * 75 / 100);
      default: return CNT_W'(PWM_PERIOD);
    endcase
  endfunction

  logic [3:0]        btn_p0;
  logic [3:0]        sync_btn;
  logic [3:0]        last_btn;
  logic [DB_W-1:0]   stab_cnt;
  logic [3:0]        stable_btn;

  state_t            state;
  state_t            next_state;

  logic signed [3:0] led_q;
  logic signed [3:0] led_nxt;
  logic [3:0]        duty_q;
  logic [3:0]        duty_nxt;

  logic [CNT_W-1:0]  pwm_cnt;
  logic [CNT_W-1:0]  thr_active;
  logic              pwm_q;

  // Stage p0/p1: two-flop synchronizer, then debounce.
  // The vector is accepted once sync_btn has matched last_btn on
  // DEBOUNCE_CYCLES consecutive edges (the change edge counts as the first).
  always_ff @(posedge clk) begin
    if (reset_n) begin
      btn_p0     <= '0;
      sync_btn   <= '0;
      last_btn   <= '0;
      stab_cnt   <= '0;
      stable_btn <= '0;
    end else begin
      btn_p0   <= bus.usr_btn;
      sync_btn <= btn_p0;
      if (sync_btn != last_btn) begin
        last_btn <= sync_btn;
        stab_cnt <= '0;
      end else begin
        if (stab_cnt != DB_LAST)
          stab_cnt <= stab_cnt + DB_W'(1);
        if (stab_cnt >= DB_TAKE)
          stable_btn <= last_btn;
      end
    end
  end

  // Stage p2: command FSM. FIRE lasts one cycle so each press acts once;
  // HOLD swallows any pattern change until everything is released.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      state  <= S_IDLE;
      led_q  <= '0;
      duty_q <= DUTY_MAX;
    end else begin
      state  <= next_state;
      led_q  <= led_nxt;
      duty_q <= duty_nxt;
    end
  end

  always_comb begin
    next_state = state;
    led_nxt    = led_q;
    duty_nxt   = duty_q;
    case (state)
      S_IDLE: if (stable_btn != 4'd0) next_state = S_FIRE;
      S_FIRE: begin
        next_state = S_HOLD;
        if (stable_btn[3])      duty_nxt = sat_inc_duty(duty_q);
        else if (stable_btn[2]) duty_nxt = sat_dec_duty(duty_q);
        else if (stable_btn[1]) led_nxt  = sat_inc_led(led_q);
        else if (stable_btn[0]) led_nxt  = sat_dec_led(led_q);
      end
      S_HOLD: if (stable_btn == 4'd0) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // PWM: free-running period counter. The threshold is only reloaded on
  // the wrap so a duty change never truncates or stretches a running period.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      pwm_cnt    <= '0;
      thr_active <= CNT_W'(PWM_PERIOD);
      pwm_q      <= 1'b0;
    end else begin
      pwm_q <= (pwm_cnt < thr_active);
      if (pwm_cnt == PWM_LAST) begin
        pwm_cnt    <= '0;
        thr_active <= thr_of(duty_q);
      end else begin
        pwm_cnt <= pwm_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.usr_led    = led_q;
  assign bus.duty_idx   = duty_q;
  assign bus.pwm_signal = pwm_q;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_lab4_btn_ctrl.sv
// Directed testbench for lab4_btn_ctrl (DEBOUNCE_CYCLES=20, PWM_PERIOD=100).
// Inputs are driven and outputs sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_lab4_btn_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  int   busy_rises = 0;
  logic busy_q = 1'b0;

  int dec_duty_exp [5] = '{3, 2, 1, 0, 0};
  int dec_high_exp [5] = '{75, 50, 25, 5, 5};
  int inc_duty_exp [2] = '{1, 2};
  int inc_high_exp [2] = '{25, 50};

  lab4_btn_ctrl_if bus();

  lab4_btn_ctrl #(
    .DEBOUNCE_CYCLES(20),
    .PWM_PERIOD(100)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Count busy rising edges so one-pulse-per-press can be checked.
  always @(posedge clk) begin
    busy_q <= bus.busy;
    if (bus.busy && !busy_q) busy_rises <= busy_rises + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] b, input int hold, input int rel);
    bus.usr_btn = b;
    tick(hold);
    bus.usr_btn = 4'b0000;
    tick(rel);
  endtask

  task automatic high_time(output int h);
    h = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.pwm_signal) h++;
      tick(1);
    end
  endtask

  initial begin
    int   r, h, w1, w2, rise2, k, exp_led;
    logic found, prev;
    logic hist [300];

    reset_n     = 1'b1;
    bus.usr_btn = 4'b0000;
    tick(100);
    check("rst_led",  $signed(bus.usr_led), 0);
    check("rst_duty", int'(bus.duty_idx), 4);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_pwm",  int'(bus.pwm_signal), 0);
    reset_n = 1'b0;
    tick(2);
    check("pwm_full_after_rst", int'(bus.pwm_signal), 1);
    tick(50);

    // First INC_COUNTER press with exact latency checks
    r = busy_rises;
    bus.usr_btn = 4'b0010;
    tick(22);
    check("busy_before_fire", int'(bus.busy), 0);
    tick(1);
    check("busy_at_fire", int'(bus.busy), 1);
    check("led_at_fire", $signed(bus.usr_led), 0);
    tick(1);
    check("led_latency24", $signed(bus.usr_led), 1);
    tick(76);
    bus.usr_btn = 4'b0000;
    tick(22);
    check("busy_release_22", int'(bus.busy), 1);
    tick(1);
    check("busy_release_23", int'(bus.busy), 0);
    tick(77);
    check("busy_pulse_1", busy_rises - r, 1);

    for (int i = 2; i <= 8; i++) begin
      r = busy_rises;
      press(4'b0010, 100, 100);
      check("inc_led", $signed(bus.usr_led), (i > 7) ? 7 : i);
      check("inc_busy_pulse", busy_rises - r, 1);
    end

    for (int i = 1; i <= 16; i++) begin
      press(4'b0001, 100, 100);
      exp_led = (7 - i < -8) ? -8 : 7 - i;
      check("dec_led", $signed(bus.usr_led), exp_led);
    end
    check("dec_led_bits", int'(bus.usr_led), 8);
    press(4'b0010, 100, 100);
    check("inc_from_min", $signed(bus.usr_led), -7);

    high_time(h);
    check("high_duty4", h, 100);

    for (int i = 0; i < 5; i++) begin
      press(4'b0100, 100, 100);
      check("dec_duty", int'(bus.duty_idx), dec_duty_exp[i]);
      high_time(h);
      check("dec_high", h, dec_high_exp[i]);
    end
    for (int i = 0; i < 2; i++) begin
      press(4'b1000, 100, 100);
      check("inc_duty", int'(bus.duty_idx), inc_duty_exp[i]);
      high_time(h);
      check("inc_high", h, inc_high_exp[i]);
    end

    // Simultaneous press held long: only INC_PWM, only once
    r = busy_rises;
    press(4'b1010, 500, 100);
    check("prio_duty", int'(bus.duty_idx), 3);
    check("prio_led", $signed(bus.usr_led), -7);
    check("prio_one_cmd", busy_rises - r, 1);
    high_time(h);
    check("prio_high", h, 75);

    // Short glitch must not issue a command
    r = busy_rises;
    bus.usr_btn = 4'b0010;
    tick(10);
    bus.usr_btn = 4'b0000;
    tick(100);
    check("glitch_led", $signed(bus.usr_led), -7);
    check("glitch_duty", int'(bus.duty_idx), 3);
    check("glitch_busy", busy_rises - r, 0);

    // Duty change landing mid-period takes effect only after the wrap
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      prev = bus.pwm_signal;
      tick(1);
      if (!prev && bus.pwm_signal) found = 1'b1;
    end
    check("pwm_rise_found", int'(found), 1);
    for (int i = 0; i < 300; i++) begin
      hist[i] = bus.pwm_signal;
      if (i == 10)  bus.usr_btn = 4'b0100;
      if (i == 110) bus.usr_btn = 4'b0000;
      tick(1);
    end
    k = 0;
    while (k < 300 && hist[k]) k++;
    w1 = k;
    while (k < 300 && !hist[k]) k++;
    rise2 = k;
    w2 = 0;
    while (k < 300 && hist[k]) begin
      w2++;
      k++;
    end
    check("midper_width_old", w1, 75);
    check("midper_next_rise", rise2, 100);
    check("midper_width_new", w2, 50);
    check("midper_duty", int'(bus.duty_idx), 2);
    tick(50);

    // Reset asserted during HOLD
    press(4'b0010, 100, 100);
    check("pre_hold_led", $signed(bus.usr_led), -6);
    bus.usr_btn = 4'b0010;
    tick(40);
    check("hold_led", $signed(bus.usr_led), -5);
    check("hold_busy", int'(bus.busy), 1);
    check("hold_duty", int'(bus.duty_idx), 2);
    reset_n = 1'b1;
    tick(1);
    check("midrst_led",  $signed(bus.usr_led), 0);
    check("midrst_duty", int'(bus.duty_idx), 4);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_pwm",  int'(bus.pwm_signal), 0);
    reset_n = 1'b0;
    tick(40);
    check("repress_led", $signed(bus.usr_led), 1);
    check("repress_busy", int'(bus.busy), 1);
    bus.usr_btn = 4'b0000;
    tick(100);
    check("final_busy", int'(bus.busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
